// File: rtl/alu_div8_seq.sv
// -----------------------------------------------------------------------------
// alu_div8_seq
//   Multi-cycle unsigned restoring divider for the CPU execute stage.
//   Each RUN cycle performs one trial subtraction of the divisor from the
//   shifted partial remainder. The carry convention matches the ALU adder:
//   no borrow (C=1) means the subtraction is kept and the quotient bit is 1.
//
//   Timing: a start accepted at edge E0 leads to done being high in the cycle
//   after edge E0+WIDTH+1. The edges E1..E0+WIDTH each retire one quotient
//   bit. The edge that follows copies the working registers into the result
//   registers and enters DONE.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   request, sampled only while busy=0
//   dividend   in   [WIDTH-1:0] numerator, latched on an accepted start
//   divisor    in   [WIDTH-1:0] denominator, latched on an accepted start
//   busy       out  high from an accepted start until the cycle after done
//   done       out  one-cycle strobe, results valid in that cycle
//   quotient   out  [WIDTH-1:0] result, held until the next DONE entry
//   remainder  out  [WIDTH-1:0] result, held until the next DONE entry
//   zero       out  quotient == 0, registered together with the results
//   div_zero   out  divisor was zero (only with DIV_ZERO_CHK_EN)
//
// Build option
//   DIV_ZERO_CHK_EN : when defined, a zero divisor skips the iterations. The
//   operation then completes one edge after the start, with quotient = all
//   ones, remainder = dividend and div_zero = 1. When undefined, a zero
//   divisor runs the normal algorithm, which yields the same quotient and
//   remainder, and div_zero is constant 0.
// -----------------------------------------------------------------------------
module alu_div8_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  // Working registers. They need no reset because they are always loaded on
  // an accepted start before anything reads them.
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] r_w;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   trial;
  logic             take_start;

`ifdef DIV_ZERO_CHK_EN
  logic             dz;
`endif

  // Trial subtraction of the divisor from the shifted remainder rs, where rs
  // is WIDTH+1 bits wide. The result is {borrow, difference}. When there is
  // no borrow, the true difference is smaller than the divisor, so the low
  // WIDTH bits of rs minus d give it exactly.
  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0]   rs,
                                               input logic [WIDTH-1:0] d);
    logic             borrow;
    logic [WIDTH-1:0] diff;
    borrow    = (rs < {1'b0, d});
    diff      = rs[WIDTH-1:0] - d;
    trial_sub = {borrow, diff};
  endfunction

  assign take_start = (state == IDLE) && start;

  // One iteration: {R,Q} shifts left and the MSB of Q moves into R.
  always_comb begin
    trial = trial_sub({r_w, q_w[WIDTH-1]}, dvs);
  end

  // ---- datapath: operand latch and shift/subtract iteration ----
  always_ff @(posedge clk) begin
    if (take_start) begin
      dvs <= divisor;
      q_w <= dividend;
      r_w <= '0;
`ifdef DIV_ZERO_CHK_EN
      dz  <= (divisor == '0);
      // A zero divisor gets its final result at once. No iterations follow,
      // because the control path loads a count of 0.
      if (divisor == '0) begin
        q_w <= '1;
        r_w <= dividend;
      end
`endif
    end else if ((state == RUN) && (count != '0)) begin
      if (!trial[WIDTH]) begin
        r_w <= trial[WIDTH-1:0];
        q_w <= {q_w[WIDTH-2:0], 1'b1};
      end else begin
        r_w <= {r_w[WIDTH-2:0], q_w[WIDTH-1]};
        q_w <= {q_w[WIDTH-2:0], 1'b0};
      end
    end
  end

  // ---- control: state, counter, status and result registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      zero      <= 1'b0;
`ifdef DIV_ZERO_CHK_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            count <= CNT_W'(WIDTH);
`ifdef DIV_ZERO_CHK_EN
            if (divisor == '0) count <= '0;
`endif
          end
        end
        RUN: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            // Every quotient bit has been retired, so publish the result.
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_w;
            remainder <= r_w;
            zero      <= (q_w == '0);
`ifdef DIV_ZERO_CHK_EN
            div_zero  <= dz;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef DIV_ZERO_CHK_EN
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_div8_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_div8_seq
//   Directed testbench for alu_div8_seq with WIDTH=8. Every expected value is
//   a hand-computed constant. Inputs are driven and outputs are sampled on the
//   falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_div8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       zero;
  logic       div_zero;

  int nvec = 0;
  int nerr = 0;

`ifdef DIV_ZERO_CHK_EN
  localparam int  DZ_LAT = 1;
  localparam logic DZ_FLAG = 1'b1;
`else
  localparam int  DZ_LAT = 9;
  localparam logic DZ_FLAG = 1'b0;
`endif

  alu_div8_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .zero      (zero),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Issues one operation and waits (bounded) for done. lat is the number of
  // edges after the accepting edge, or -1 on timeout. nb counts busy cycles
  // before done. busy_gap flags any pre-done cycle with busy low. If inj >= 0,
  // a 50/5 start pulse is driven in that post-start cycle. After done, the
  // task advances one more cycle and reports done and busy.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, input int inj,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic z, output logic dz, output int lat,
                        output int nb, output logic busy_gap,
                        output logic done_after, output logic busy_after);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    lat      = -1;
    nb       = 0;
    busy_gap = 1'b0;
    q = '0; r = '0; z = 1'b0; dz = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        lat = k;
        q = quotient; r = remainder; z = zero; dz = div_zero;
        break;
      end
      if (busy) nb++;
      else busy_gap = 1'b1;
      if (k == inj) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if ({busy, done, zero, div_zero, quotient, remainder} !== 20'h0) begin
      nerr++;
      $display("FAIL reset_state: got busy=%b done=%b z=%b dz=%b q=%0d r=%0d, want all 0",
               busy, done, zero, div_zero, quotient, remainder);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] q, r; logic z, dz, gap, da, ba; int lat, nb;
    do_div(8'd200, 8'd7, -1, q, r, z, dz, lat, nb, gap, da, ba);
    nvec++; if (lat !== 9) begin nerr++; $display("FAIL lat_200_7: got %0d want 9", lat); end
    nvec++; if ({q, r} !== {8'd28, 8'd4}) begin nerr++; $display("FAIL res_200_7: got %0d/%0d want 28/4", q, r); end
    nvec++; if (z !== 1'b0) begin nerr++; $display("FAIL zero_200_7: got %b want 0", z); end
    nvec++; if (nb !== 9 || gap !== 1'b0) begin nerr++; $display("FAIL busy_200_7: got %0d cycles gap=%b want 9 gap=0", nb, gap); end
    nvec++; if ({da, ba} !== 2'b00) begin nerr++; $display("FAIL after_done: got done=%b busy=%b want 0 0", da, ba); end
    repeat (3) @(negedge clk);
    nvec++; if ({quotient, remainder, zero} !== {8'd28, 8'd4, 1'b0}) begin
      nerr++; $display("FAIL hold_idle: got %0d/%0d z=%b want 28/4 z=0", quotient, remainder, zero);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] q, r; logic z, dz, gap, da, ba; int lat, nb;
    do_div(8'd255, 8'd1, -1, q, r, z, dz, lat, nb, gap, da, ba);
    nvec++; if ({q, r, z} !== {8'd255, 8'd0, 1'b0}) begin nerr++; $display("FAIL res_255_1: got %0d/%0d z=%b want 255/0 z=0", q, r, z); end
    do_div(8'd0, 8'd1, -1, q, r, z, dz, lat, nb, gap, da, ba);
    nvec++; if ({q, r, z} !== {8'd0, 8'd0, 1'b1}) begin nerr++; $display("FAIL res_0_1: got %0d/%0d z=%b want 0/0 z=1", q, r, z); end
    do_div(8'd5, 8'd9, -1, q, r, z, dz, lat, nb, gap, da, ba);
    nvec++; if ({q, r, z} !== {8'd0, 8'd5, 1'b1}) begin nerr++; $display("FAIL res_5_9: got %0d/%0d z=%b want 0/5 z=1", q, r, z); end
    do_div(8'd255, 8'd255, -1, q, r, z, dz, lat, nb, gap, da, ba);
    nvec++; if ({q, r, z} !== {8'd1, 8'd0, 1'b0}) begin nerr++; $display("FAIL res_255_255: got %0d/%0d z=%b want 1/0 z=0", q, r, z); end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r; logic z, dz, gap, da, ba; int lat, nb;
    do_div(8'd100, 8'd0, -1, q, r, z, dz, lat, nb, gap, da, ba);
    nvec++; if (lat !== DZ_LAT) begin nerr++; $display("FAIL lat_div0: got %0d want %0d", lat, DZ_LAT); end
    nvec++; if ({q, r, z} !== {8'd255, 8'd100, 1'b0}) begin nerr++; $display("FAIL res_div0: got %0d/%0d z=%b want 255/100 z=0", q, r, z); end
    nvec++; if (dz !== DZ_FLAG) begin nerr++; $display("FAIL flag_div0: got %b want %b", dz, DZ_FLAG); end
    do_div(8'd60, 8'd8, -1, q, r, z, dz, lat, nb, gap, da, ba);
    nvec++; if ({q, r, dz} !== {8'd7, 8'd4, 1'b0}) begin nerr++; $display("FAIL dz_clear: got %0d/%0d dz=%b want 7/4 dz=0", q, r, dz); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, r; logic z, dz, gap, da, ba; int lat, nb;
    do_div(8'd200, 8'd7, 3, q, r, z, dz, lat, nb, gap, da, ba);
    nvec++; if ({q, r} !== {8'd28, 8'd4} || lat !== 9) begin
      nerr++; $display("FAIL ignore_busy_start: got %0d/%0d lat=%0d want 28/4 lat=9", q, r, lat);
    end
    // do_div returns in the first IDLE cycle after done.
    do_div(8'd50, 8'd5, -1, q, r, z, dz, lat, nb, gap, da, ba);
    nvec++; if ({q, r} !== {8'd10, 8'd0} || lat !== 9) begin
      nerr++; $display("FAIL back_to_back: got %0d/%0d lat=%0d want 10/0 lat=9", q, r, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] q, r; logic z, dz, gap, da, ba; int lat, nb;
    logic saw_done;
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nvec++;
    if ({busy, done, zero, div_zero, quotient, remainder} !== 20'h0) begin
      nerr++;
      $display("FAIL async_reset: got busy=%b done=%b z=%b dz=%b q=%0d r=%0d, want all 0",
               busy, done, zero, div_zero, quotient, remainder);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    nvec++; if (saw_done !== 1'b0) begin nerr++; $display("FAIL abort_no_done: got activity=%b want 0", saw_done); end
    do_div(8'd60, 8'd8, -1, q, r, z, dz, lat, nb, gap, da, ba);
    nvec++; if ({q, r} !== {8'd7, 8'd4} || lat !== 9) begin
      nerr++; $display("FAIL after_reset: got %0d/%0d lat=%0d want 7/4 lat=9", q, r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
